// File: rtl/cnt_seq_pkg.sv
// Shared command encodings and FSM state type for the counter sequencer.
package cnt_seq_pkg;

  typedef enum logic [1:0] {
    OP_SYNC = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } cnt_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_CHECK = 3'd4
  } cnt_seq_state_e;

endpackage

// File: rtl/cnt_seq_model.sv
// Expected-value model of the up/down counter plus the sticky compare.
// The compare exists only when CNT_SEQ_CHECK_EN is defined; otherwise o_mismatch is tied 0.
module cnt_seq_model #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             i_sync,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_check,
  input  logic [WIDTH-1:0] i_cnt_q,
  output logic [WIDTH-1:0] o_expected,
  output logic             o_mismatch
);

  logic [WIDTH-1:0] r_expected;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, just like the hardware.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_expected <= '0;
    end else if (i_sync) begin
      r_expected <= i_cnt_q;
    end else if (i_load) begin
      r_expected <= i_load_val;
    end else if (i_inc) begin
      r_expected <= r_expected + WIDTH'(1);
    end else if (i_dec) begin
      r_expected <= r_expected - WIDTH'(1);
    end
  end

  assign o_expected = r_expected;

`ifdef CNT_SEQ_CHECK_EN
  logic r_mismatch;
  logic w_diff;

  assign w_diff = i_check && (i_cnt_q != r_expected);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_mismatch <= 1'b0;
    end else if (w_diff) begin
      r_mismatch <= 1'b1;
    end
  end

  // Visible already in the CHECK cycle, then held by the sticky flop.
  assign o_mismatch = r_mismatch | w_diff;
`else
  logic w_unused_check;
  assign w_unused_check = i_check;
  assign o_mismatch     = 1'b0;
`endif

endmodule

// File: rtl/cnt_sequencer.sv
// Command-driven initiator for the 16-bit up/down counter control interface.
// Define CNT_SEQ_CHECK_EN to add the CHECK state and the sticky mismatch compare.
module cnt_sequencer
  import cnt_seq_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] cnt_q,
  output logic [WIDTH-1:0] data_in,
  output logic             ld_cnt,
  output logic             updn_cnt,
  output logic             count_enb,
  output logic             done,
  output logic [WIDTH-1:0] expected,
  output logic             mismatch
);

`ifdef CNT_SEQ_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  cnt_seq_state_e   r_state, w_next;
  logic [STEP_W-1:0] r_steps;
  logic              r_dir;
  logic [WIDTH-1:0]  r_data_in;
  logic              w_accept;
  logic              w_run_en;
  logic              w_run_last;
  cnt_op_e           w_op;
  logic [STEP_W-1:0] w_n;

  assign w_op       = cnt_op_e'(cmd_op);
  assign w_n        = cmd_data[STEP_W-1:0];
  assign w_accept   = cmd_valid && (r_state == S_IDLE);
  // A zero step count only reaches RUN when there is no CHECK state to absorb it.
  assign w_run_en   = (r_state == S_RUN) && (r_steps != '0);
  assign w_run_last = (r_state == S_RUN) && (r_steps <= STEP_W'(1));

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state   <= S_IDLE;
      r_steps   <= '0;
      r_dir     <= 1'b0;
      r_data_in <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        if (w_op == OP_LOAD) begin
          r_data_in <= cmd_data;
        end
        if (w_op == OP_UP || w_op == OP_DOWN) begin
          r_steps <= w_n;
          r_dir   <= (w_op == OP_UP);
        end
      end else if (w_run_en) begin
        r_steps <= r_steps - STEP_W'(1);
      end
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          unique case (w_op)
            OP_SYNC: w_next = S_SYNC;
            OP_LOAD: w_next = S_LOAD;
            default: w_next = (w_n == '0 && CHECK_EN) ? S_CHECK : S_RUN;
          endcase
        end
      end
      S_SYNC: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      S_LOAD: begin
        done   = !CHECK_EN;
        w_next = CHECK_EN ? S_CHECK : S_IDLE;
      end
      S_RUN: begin
        if (w_run_last) begin
          done   = !CHECK_EN;
          w_next = CHECK_EN ? S_CHECK : S_IDLE;
        end
      end
      S_CHECK: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign ld_cnt    = (r_state == S_LOAD);
  assign count_enb = w_run_en;
  assign updn_cnt  = w_run_en & r_dir;
  assign data_in   = r_data_in;

  cnt_seq_model #(
    .WIDTH(WIDTH)
  ) u_model (
    .clk       (clk),
    .rst_      (rst_),
    .i_sync    (r_state == S_SYNC),
    .i_load    (r_state == S_LOAD),
    .i_load_val(r_data_in),
    .i_inc     (w_run_en & r_dir),
    .i_dec     (w_run_en & ~r_dir),
    .i_check   (r_state == S_CHECK),
    .i_cnt_q   (cnt_q),
    .o_expected(expected),
    .o_mismatch(mismatch)
  );

endmodule

// File: tb/tb_cnt_sequencer.sv
// Directed bench for cnt_sequencer with a behavioural counter stub on the control interface.
// Expectations follow whichever CNT_SEQ_CHECK_EN build is compiled.
module tb_cnt_sequencer;
  import cnt_seq_pkg::*;

`ifdef CNT_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [15:0] cnt_q;
  logic [15:0] data_in;
  logic        ld_cnt, updn_cnt, count_enb, done, mismatch;
  logic [15:0] expected;

  logic [15:0] r_ctr = '0;
  logic [15:0] skew;
  logic        force_en;
  logic [15:0] force_val;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_cnt)         r_ctr <= data_in;
    else if (count_enb) r_ctr <= updn_cnt ? r_ctr + 16'd1 : r_ctr - 16'd1;
  end

  assign cnt_q = force_en ? force_val : r_ctr + skew;

  cnt_sequencer #(.WIDTH(16), .STEP_W(8)) dut (
    .clk      (clk),
    .rst_     (rst_),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .cnt_q    (cnt_q),
    .data_in  (data_in),
    .ld_cnt   (ld_cnt),
    .updn_cnt (updn_cnt),
    .count_enb(count_enb),
    .done     (done),
    .expected (expected),
    .mismatch (mismatch)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 40 && !cmd_ready; i++) tick();
    check(tag, cmd_ready, 1);
  endtask

  // Returns one step into cycle k+1, where k is the accepting edge.
  task automatic send(input cnt_op_e op, input logic [15:0] data);
    wait_ready("ready_before_cmd");
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_data  = 16'h5A5A;
  endtask

  initial begin
    rst_ = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0;
    skew = '0; force_en = 1'b0; force_val = '0;

    #12;
    check("rst_ready", cmd_ready, 1);
    check("rst_ctrl", {ld_cnt, updn_cnt, count_enb, done}, 0);
    check("rst_data_in", data_in, 0);
    check("rst_expected", expected, 0);
    check("rst_mismatch", mismatch, 0);
    @(negedge clk); rst_ = 1'b1;
    tick();

    // LOAD 1234
    send(OP_LOAD, 16'h1234);
    check("ld_strobe", {ld_cnt, count_enb}, 2'b10);
    check("ld_data_in", data_in, 16'h1234);
    check("ld_done_k1", done, !CHK);
    check("ld_busy", cmd_ready, 0);
    tick();
    check("ld_strobe_off", ld_cnt, 0);
    check("ld_expected", expected, 16'h1234);
    check("ld_done_k2", done, CHK);
    check("ld_ready_k2", cmd_ready, !CHK);
    wait_ready("ld_finish");
    check("ld_mismatch", mismatch, 0);
    check("ld_data_hold", data_in, 16'h1234);

    // LOAD FFFE then UP 3 wraps through zero
    send(OP_LOAD, 16'hFFFE);
    wait_ready("ld2_finish");
    send(OP_UP, 16'h0003);
    check("up_c1", {ld_cnt, count_enb, updn_cnt, done}, 4'b0110);
    tick();
    check("up_c2", {count_enb, updn_cnt}, 2'b11);
    check("up_exp_c2", expected, 16'hFFFF);
    tick();
    check("up_c3", {count_enb, updn_cnt, done}, {2'b11, !CHK});
    check("up_exp_c3", expected, 16'h0000);
    tick();
    check("up_c4", {count_enb, updn_cnt, done}, {2'b00, CHK});
    check("up_exp_wrap", expected, 16'h0001);
    wait_ready("up_finish");
    check("up_mismatch", mismatch, 0);

    // LOAD 0 then DOWN 1 wraps to FFFF
    send(OP_LOAD, 16'h0000);
    wait_ready("ld3_finish");
    send(OP_DOWN, 16'h0001);
    check("dn_c1", {count_enb, updn_cnt, done}, {2'b10, !CHK});
    tick();
    check("dn_c2", {count_enb, updn_cnt, done}, {2'b00, CHK});
    check("dn_exp", expected, 16'hFFFF);
    wait_ready("dn_finish");
    check("dn_mismatch", mismatch, 0);

    // UP with N=0: no enable, done in k+1; upper cmd_data bits ignored
    send(OP_UP, 16'hAB00);
    check("n0_c1", {count_enb, ld_cnt, done}, 3'b001);
    tick();
    check("n0_idle", {cmd_ready, done}, 2'b10);
    check("n0_exp", expected, 16'hFFFF);

    // Counter stub off by one across UP 2
    skew = 16'd1;
    send(OP_UP, 16'h0002);
    tick();
    tick();
    check("skew_c3_enb", count_enb, 0);
    check("skew_mm_check", mismatch, CHK);
    tick();
    check("skew_mm_hold", mismatch, CHK);
    skew = 16'd0;
    send(OP_SYNC, 16'h0000);
    check("sync1_done", done, 1);
    tick();
    check("sync1_exp", expected, 16'h0001);
    check("skew_mm_sticky", mismatch, CHK);

    // Async reset in the third cycle of UP 10
    send(OP_UP, 16'h000A);
    tick();
    tick();
    check("abort_enb_c3", count_enb, 1);
    #2 rst_ = 1'b0;
    #1;
    check("abort_ready", cmd_ready, 1);
    check("abort_ctrl", {ld_cnt, updn_cnt, count_enb, done}, 0);
    check("abort_exp", expected, 0);
    check("abort_data_in", data_in, 0);
    check("abort_mismatch", mismatch, 0);
    @(negedge clk); rst_ = 1'b1;
    tick();

    // SYNC after reset picks up the forced counter value
    force_en = 1'b1; force_val = 16'h00AA;
    send(OP_SYNC, 16'h0000);
    check("sync2_done", {done, count_enb, ld_cnt}, 3'b100);
    tick();
    check("sync2_exp", expected, 16'h00AA);
    check("sync2_ready", cmd_ready, 1);
    check("sync2_mismatch", mismatch, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cnt_sequencer.md
# cnt_sequencer

Command-driven initiator for the 16-bit up/down counter's control interface. Accepts load/count/sync commands over a valid/ready handshake, drives `data_in`, `ld_cnt`, `updn_cnt` and `count_enb` cycle-accurately, and tracks a modulo-2^WIDTH expected value. It compares that value against the counter's `data_out` and flags divergence. It sits between a test or system controller and the counter instance.

## Interface
- `WIDTH`, 16, counter data width.
- `STEP_W`, 8, width of the step count for UP/DOWN commands.
- `clk` in 1: single clock, all logic on posedge.
- `rst_` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer idle; a command is accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_op` in 2: operation. 00 SYNC, 01 LOAD, 10 UP, 11 DOWN.
- `cmd_data` in WIDTH: load value (LOAD); `cmd_data[STEP_W-1:0]` is the step count N (UP/DOWN). Ignored for SYNC.
- `cnt_q` in WIDTH: counter `data_out` feedback.
- `data_in` out WIDTH: counter load value.
- `ld_cnt` out 1: counter load strobe.
- `updn_cnt` out 1: count direction, 1 = up.
- `count_enb` out 1: counter enable.
- `done` out 1: one-cycle pulse at command completion.
- `expected` out WIDTH: model value.
- `mismatch` out 1: sticky compare error.

## Operation
- States: IDLE, SYNC, LOAD, RUN, CHECK. `cmd_ready` = (state == IDLE).
- IDLE → accept: SYNC → SYNC, LOAD → LOAD, UP/DOWN with N>0 → RUN, UP/DOWN with N=0 → CHECK.
- SYNC, one cycle: `expected <= cnt_q`; `done`=1; → IDLE. No compare.
- LOAD, one cycle: `ld_cnt`=1, `data_in`=latched value; `expected <= value`; → CHECK.
- RUN, exactly N cycles: `count_enb`=1, `updn_cnt`=dir.
  - Each cycle: `expected <= expected ± 1`, modulo 2^WIDTH. 16'hFFFF+1 = 0; 0−1 = 16'hFFFF.
  - Internal down-counter is loaded with N; leave RUN when it reaches 1.
- CHECK, one cycle: if `cnt_q != expected`, set `mismatch`. `done`=1; → IDLE.
- `ld_cnt` and `count_enb` are never asserted in the same cycle.
- `data_in` holds its last load value; 0 after reset.
- `updn_cnt` is 0 outside RUN.
- `mismatch` clears only on reset.
- `cmd_valid` while busy: held off by `cmd_ready`=0; no loss, no queueing.

## Timing
- Reset (async assert, sync deassert handled externally): state IDLE; `cmd_ready`=1; all other outputs 0, including `expected` and `mismatch`.
- Reset mid-RUN or mid-LOAD: immediate abort, outputs to reset values, command dropped.
- Accept at edge k. First control cycle is k+1.
- LOAD: `ld_cnt` high in cycle k+1; `done` in k+2; `cmd_ready` back in k+3.
- UP/DOWN N: `count_enb` high in cycles k+1..k+N; `done` in k+N+1; `cmd_ready` in k+N+2.
- UP/DOWN with N=0: no enable; `done` in k+1.
- SYNC: `done` in k+1.
- Counter contract: it updates on the edge that samples the strobe, so `cnt_q` in CHECK reflects the final edge.

## Configuration
- `CNT_SEQ_CHECK_EN` defined: CHECK state and `mismatch` logic as above.
- `CNT_SEQ_CHECK_EN` undefined: no CHECK state; `mismatch` tied 0.
  - LOAD/RUN assert `done` in their last drive cycle.
  - N=0 and SYNC complete in k+1.
  - Each command finishes one cycle earlier.

## Structure
- Package `cnt_seq_pkg`: `cnt_op_e` (SYNC/LOAD/UP/DOWN encodings) and `cnt_seq_state_e`.
- Sub-module `cnt_seq_model`: the expected-value register with load, inc, dec and sync controls, plus the compare. The FSM lives in `cnt_sequencer`.

## Test plan
- Reset then idle → `cmd_ready`=1, all controls 0, `expected`=0, `mismatch`=0.
- LOAD 16'h1234, counter model correct → `ld_cnt` for 1 cycle with `data_in`=16'h1234; `done` at k+2; `mismatch`=0.
- LOAD 16'hFFFE, then UP N=3 → `count_enb` for 3 cycles, `updn_cnt`=1; `expected`=16'h0001 (wrap); `done` at k+4.
- LOAD 0, then DOWN N=1 → `expected`=16'hFFFF; no mismatch.
- Counter stub forced off by one after UP N=2 → `mismatch` rises in CHECK and stays high across later commands until `rst_` low. Also: UP N=0 → no enable, `done` at k+1.
- Reset asserted in the 3rd cycle of UP N=10 → outputs cleared asynchronously; next command accepted normally. SYNC with `cnt_q`=16'h00AA → `expected`=16'h00AA.
